addsub_mp_sequencer: RTL
========================

Name: addsub_mp_sequencer

Overview:
- Multi-precision add/subtract sequencer built on one shared WIDTH-bit post-adder stage with carry chaining.
- Two requesters share the stage under round-robin arbitration.
- Each granted operation processes one WIDTH-bit word per cycle, LSW first, over WORDS cycles.
- Result and carry/borrow are returned to the granted requester with a one-cycle done pulse.
- Sits between DSP slice users (accumulator and pre-adder feed logic) and the adder datapath.

Parameters:
- WIDTH, 18, word width of the shared adder stage.
- WORDS, 3, words per operand; operand width is WIDTH*WORDS; legal range 1..8.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; level, held until done0.
- op0  in  1  port 0 operation: 0 = add, 1 = subtract.
- a0  in  WIDTH*WORDS  port 0 operand A.
- b0  in  WIDTH*WORDS  port 0 operand B.
- req1, op1, a1, b1  in  1/1/WIDTH*WORDS/WIDTH*WORDS  port 1, same meaning as port 0.
- gnt  out  2  one-hot current owner; 00 when idle.
- busy  out  1  high while in RUN.
- res  out  WIDTH*WORDS  result of the last completed operation.
- cout  out  1  add: carry out of the MSW; subtract: borrow (1 iff A < B unsigned).
- done0  out  1  one-cycle pulse: port 0 result valid on res/cout.
- done1  out  1  one-cycle pulse: port 1 result valid on res/cout.

Behaviour:
- Reset values: all outputs 0; internal state IDLE; word index 0; carry register 0; last-grant pointer = 1, so port 0 wins first.
- States: IDLE and RUN.
- IDLE:
  - Sample req0/req1 at each edge.
  - Only one requesting: grant it.
  - Both requesting: grant the port not equal to last-grant.
  - On the grant edge: latch op, A and B into internal registers; set gnt one-hot; update last-grant; initialise carry = op (1 for subtract); set word index = 0; go to RUN.
- RUN:
  - Each edge processes word k: sum = A[k] + (op ? ~B[k] : B[k]) + carry.
  - Store the low WIDTH bits into result word k; carry <= bit WIDTH.
  - Arithmetic is unsigned, modulo 2^(WIDTH*WORDS).
- Completion edge (k = WORDS-1):
  - Register the full result onto res.
  - cout = final carry for add, inverted final carry for subtract.
  - Pulse the owner's doneN for exactly the following cycle.
  - gnt <= 00, busy <= 0, state -> IDLE.
- Latency and throughput:
  - Grant at edge t; doneN high in the cycle after edge t+WORDS.
  - One operation per WORDS+1 cycles.
- Operand capture: operands and op are captured at grant. Input changes or req deassertion during RUN are ignored, and the operation always completes.
- Repeat requests: a requester that keeps reqN high through its done cycle is re-arbitrated at the next edge. With both ports continuously requesting, grants alternate.
- Output hold: res and cout hold their value between completions and change only on a completion edge.
- Reset mid-operation: immediate return to the reset state. No done pulse; the in-flight operation is discarded.
- WORDS=1: a single RUN cycle.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined: unsigned saturation on the completion edge.
  - Add with cout=1: res = all ones.
  - Subtract with borrow=1: res = 0.
  - cout is still reported unchanged.
- Undefined: res wraps modulo 2^(WIDTH*WORDS).
- Latency is identical in both builds.

Test Plan (WIDTH=18, WORDS=3, 54-bit operands):
- Port 0 add, a0=0x3FFFF, b0=0x1 -> done0 three cycles after the grant edge; res=0x40000 (carry crosses word 0 to word 1), cout=0, gnt=01 while busy.
- Port 1 subtract, a1=5, b1=7 -> res=0x3FFFFFFFFFFFFE, cout=1, done1 only (done0 stays 0).
- Port 0 add, a0=0x3FFFFFFFFFFFFF, b0=1 -> res=0, cout=1. With ADDSUB_SAT_EN: res=0x3FFFFFFFFFFFFF, cout=1. Also with ADDSUB_SAT_EN: the previous subtract case gives res=0.
- req0 and req1 both asserted on the first cycle after reset and held -> grants 01, 10, 01, 10, with done pulses alternating every 4 cycles.
- RST pulsed while word 1 of a port 0 add is processing -> gnt=00, busy=0, res=0, no done0. A new request after release completes correctly.
- Change a0/b0 and drop req0 one cycle after grant -> res equals the sum of the values captured at grant.

Source files
------------

// File: rtl/addsub_mp_sequencer.sv
// -----------------------------------------------------------------------------
// addsub_mp_sequencer
//
// Purpose:
//   A multi-precision unsigned add/subtract sequencer. Two requesters share one
//   WIDTH-bit adder stage under round-robin arbitration. Each granted operation
//   runs over WORDS cycles, one word per cycle, least significant word first.
//   The carry is chained from word to word.
//
// Optional build macro:
//   ADDSUB_SAT_EN - when defined, the result saturates on the completion edge.
//                   An add with carry-out gives all ones. A subtract with
//                   borrow gives zero. cout is reported unchanged and the
//                   latency is the same in both builds.
//
// Ports:
//   CLK           clock, rising edge
//   RST           asynchronous active-high reset
//   req0/req1     level requests, held until the matching done pulse
//   op0/op1       0 = add, 1 = subtract (A - B)
//   a0,b0/a1,b1   WIDTH*WORDS-bit operands, captured at grant
//   gnt           one-hot current owner, 00 when idle
//   busy          high while an operation is running
//   res           result of the last completed operation (held)
//   cout          add: carry out; subtract: borrow (A < B)
//   done0/done1   one-cycle pulse: result for that port is valid on res/cout
// -----------------------------------------------------------------------------
module addsub_mp_sequencer #(
  parameter int WIDTH = 18,
  parameter int WORDS = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req0,
  input  logic                     op0,
  input  logic [WIDTH*WORDS-1:0]   a0,
  input  logic [WIDTH*WORDS-1:0]   b0,
  input  logic                     req1,
  input  logic                     op1,
  input  logic [WIDTH*WORDS-1:0]   a1,
  input  logic [WIDTH*WORDS-1:0]   b1,
  output logic [1:0]               gnt,
  output logic                     busy,
  output logic [WIDTH*WORDS-1:0]   res,
  output logic                     cout,
  output logic                     done0,
  output logic                     done1
);

  localparam int N     = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_last;      // 1 = port 1 was granted last
  logic               r_op;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic [N-1:0]       r_acc;
  logic [1:0]         r_gnt;
  logic               r_busy;
  logic [N-1:0]       r_res;
  logic               r_cout;
  logic               r_done0;
  logic               r_done1;

  logic               w_grant;
  logic               w_pick1;
  logic               w_complete;
  logic [WIDTH-1:0]   w_a_word;
  logic [WIDTH-1:0]   w_b_word;
  logic [WIDTH:0]     w_sum;
  logic               w_cout_final;
  logic [N-1:0]       w_result;
  logic [N-1:0]       w_res_final;

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state / control decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_pick1      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_grant      = 1'b1;
          // On contention the port that was not served last wins.
          w_pick1      = (req0 && req1) ? ~r_last : req1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_idx == IDX_W'(WORDS - 1)) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word select and shared adder stage
  // ---------------------------------------------------------------------------
  always_comb begin
    w_a_word = '0;
    w_b_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_word = r_a[k*WIDTH +: WIDTH];
        w_b_word = r_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Subtract is A + ~B + 1; the initial 1 comes from the carry seeded at grant.
  assign w_sum = {1'b0, w_a_word}
               + {1'b0, (r_op ? ~w_b_word : w_b_word)}
               + {{WIDTH{1'b0}}, r_carry};

  // For subtract, a final carry of 0 means a borrow occurred.
  assign w_cout_final = r_op ? ~w_sum[WIDTH] : w_sum[WIDTH];

  // Full result: the word being processed now comes straight from the adder,
  // the others from the accumulator.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_result
      assign w_result[gi*WIDTH +: WIDTH] =
        (r_idx == IDX_W'(gi)) ? w_sum[WIDTH-1:0] : r_acc[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    w_res_final = w_result;
`ifdef ADDSUB_SAT_EN
    if (w_cout_final) begin
      w_res_final = r_op ? '0 : '1;
    end
`else
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_last  <= 1'b1;
      r_op    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_gnt   <= 2'b00;
      r_busy  <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_grant) begin
        r_op    <= w_pick1 ? op1 : op0;
        r_a     <= w_pick1 ? a1 : a0;
        r_b     <= w_pick1 ? b1 : b0;
        r_carry <= w_pick1 ? op1 : op0;
        r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
        r_last  <= w_pick1;
        r_idx   <= '0;
        r_busy  <= 1'b1;
      end else if (r_state == S_RUN) begin
        for (int k = 0; k < WORDS; k++) begin
          if (r_idx == IDX_W'(k)) begin
            r_acc[k*WIDTH +: WIDTH] <= w_sum[WIDTH-1:0];
          end
        end
        r_carry <= w_sum[WIDTH];
        r_idx   <= r_idx + IDX_W'(1);
        if (w_complete) begin
          r_res   <= w_res_final;
          r_cout  <= w_cout_final;
          r_done0 <= r_gnt[0];
          r_done1 <= r_gnt[1];
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
      end
    end
  end

  assign gnt   = r_gnt;
  assign busy  = r_busy;
  assign res   = r_res;
  assign cout  = r_cout;
  assign done0 = r_done0;
  assign done1 = r_done1;

endmodule
